// File: rtl/rv.sv
// Multicycle RV32I core with word-organised internal memory, register file and control unit.
// Top rv exposes the shared data bus and the memory byte address for observation.

module rv_mem #(
  parameter int MEM_WORDS = 16384,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] word_addr,
  input  logic [3:0]    wmask,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:MEM_WORDS-1];
  logic [31:0] merged_s;

  assign rdata = mem[word_addr];

  // Merge the written byte lanes into the current word
  always_comb begin
    merged_s = rdata;
    for (int i = 0; i < 4; i++) begin
      if (wmask[i]) merged_s[8*i +: 8] = wdata[8*i +: 8];
      else          merged_s[8*i +: 8] = rdata[8*i +: 8];
    end
  end

  // Word write; contents are deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (wmask != 4'b0000) mem[word_addr] <= merged_s;
  end
endmodule

module rv_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] regs [0:31];

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

  // Register array; x0 writes are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end
endmodule

module rv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        reg_we,
  output logic [4:0]  rd,
  output logic [31:0] reg_wdata,
  output logic [31:0] bus,
  output logic [31:0] addr,
  output logic [31:0] inst,
  output logic [2:0]  func3,
  output logic [4:0]  control_lines
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                         OP_SYS = 7'b1110011;

  state_t      state_r, state_next_s;
  logic [31:0] pc_r, a_r, b_r, imm_r, alu_r, mdr_r;
  logic [31:0] imm_s, op_b_s, alu_s, load_s, npc_s, pc4_s, store_data_s;
  logic [3:0]  store_mask_s;
  logic [6:0]  opcode_s;
  logic        taken_s, halt_s, is_mem_s;

  assign opcode_s      = inst[6:0];
  assign func3         = inst[14:12];
  assign rs1           = inst[19:15];
  assign rs2           = inst[24:20];
  assign rd            = inst[11:7];
  assign pc4_s         = pc_r + 32'd4;
  assign is_mem_s      = (opcode_s == OP_LOAD) || (opcode_s == OP_STORE);
  assign halt_s        = (opcode_s == OP_SYS) && (func3 == 3'b000) &&
                         ((inst[31:20] == 12'd0) || (inst[31:20] == 12'd1));
  assign control_lines = {reg_we, (mem_wmask != 4'b0000), state_r};

  // Immediate generation per instruction format
  always_comb begin
    imm_s = {{20{inst[31]}}, inst[31:20]};
    case (opcode_s)
      OP_LUI, OP_AUIPC: imm_s = {inst[31:12], 12'd0};
      OP_JAL:   imm_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      OP_BR:    imm_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_STORE: imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      default:  imm_s = {{20{inst[31]}}, inst[31:20]};
    endcase
  end

  // ALU: non-arithmetic opcodes only need rs1 + imm (addresses, JALR target)
  always_comb begin
    op_b_s = (opcode_s == OP_REG) ? b_r : imm_r;
    alu_s  = a_r + op_b_s;
    if ((opcode_s == OP_REG) || (opcode_s == OP_IMM)) begin
      case (func3)
        3'b000:  alu_s = ((opcode_s == OP_REG) && inst[30]) ? (a_r - op_b_s) : (a_r + op_b_s);
        3'b001:  alu_s = a_r << op_b_s[4:0];
        3'b010:  alu_s = {31'd0, ($signed(a_r) < $signed(op_b_s))};
        3'b011:  alu_s = {31'd0, (a_r < op_b_s)};
        3'b100:  alu_s = a_r ^ op_b_s;
        3'b101:  alu_s = inst[30] ? $unsigned($signed(a_r) >>> op_b_s[4:0]) : (a_r >> op_b_s[4:0]);
        3'b110:  alu_s = a_r | op_b_s;
        default: alu_s = a_r & op_b_s;
      endcase
    end else begin
      alu_s = a_r + op_b_s;
    end
  end

  // Branch condition, next PC, load extraction and store lanes
  always_comb begin
    case (func3)
      3'b000:  taken_s = (a_r == b_r);
      3'b001:  taken_s = (a_r != b_r);
      3'b100:  taken_s = ($signed(a_r) < $signed(b_r));
      3'b101:  taken_s = ($signed(a_r) >= $signed(b_r));
      3'b110:  taken_s = (a_r < b_r);
      3'b111:  taken_s = (a_r >= b_r);
      default: taken_s = 1'b0;
    endcase
    case (opcode_s)
      OP_JAL:  npc_s = pc_r + imm_r;
      OP_JALR: npc_s = alu_r & 32'hFFFF_FFFE;
      OP_BR:   npc_s = taken_s ? (pc_r + imm_r) : pc4_s;
      default: npc_s = pc4_s;
    endcase
    load_s = mem_rdata;
    case (func3)
      3'b000:  load_s = {{24{load_s[7]}}, load_s[7:0]};
      3'b001:  load_s = {{16{load_s[15]}}, load_s[15:0]};
      3'b100:  load_s = {24'd0, load_s[7:0]};
      3'b101:  load_s = {16'd0, load_s[15:0]};
      default: load_s = mem_rdata;
    endcase
    if ((func3 == 3'b001) || (func3 == 3'b101)) load_s = {16'd0, mem_rdata[{alu_r[1], 4'b0000} +: 16]};
    else if ((func3 == 3'b000) || (func3 == 3'b100)) load_s = {24'd0, mem_rdata[{alu_r[1:0], 3'b000} +: 8]};
    else load_s = mem_rdata;
    case (func3)
      3'b000:  load_s = {{24{load_s[7]}}, load_s[7:0]};
      3'b001:  load_s = {{16{load_s[15]}}, load_s[15:0]};
      default: load_s = load_s;
    endcase
    case (func3)
      3'b000:  begin store_mask_s = 4'b0001 << alu_r[1:0]; store_data_s = {4{b_r[7:0]}}; end
      3'b001:  begin store_mask_s = alu_r[1] ? 4'b1100 : 4'b0011; store_data_s = {2{b_r[15:0]}}; end
      default: begin store_mask_s = 4'b1111; store_data_s = b_r; end
    endcase
  end

  // Write-back selection and memory/register write strobes
  always_comb begin
    reg_we = 1'b0;
    case (opcode_s)
      OP_LUI:         reg_wdata = imm_r;
      OP_AUIPC:       reg_wdata = pc_r + imm_r;
      OP_JAL, OP_JALR: reg_wdata = pc4_s;
      OP_LOAD:        reg_wdata = mdr_r;
      OP_IMM, OP_REG: reg_wdata = alu_r;
      default:        reg_wdata = 32'd0;
    endcase
    if (state_r == WB) begin
      case (opcode_s)
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG: reg_we = 1'b1;
        OP_SYS:  reg_we = (func3 != 3'b000);
        default: reg_we = 1'b0;
      endcase
    end else begin
      reg_we = 1'b0;
    end
    mem_wdata = store_data_s;
    if ((state_r == MEM) && (opcode_s == OP_STORE)) mem_wmask = store_mask_s;
    else mem_wmask = 4'b0000;
  end

  // Next state and observation ports
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FETCH:   state_next_s = DECODE;
      DECODE:  state_next_s = EXEC;
      EXEC:    state_next_s = halt_s ? HALT : (is_mem_s ? MEM : WB);
      MEM:     state_next_s = WB;
      WB:      state_next_s = FETCH;
      HALT:    state_next_s = HALT;
      default: state_next_s = FETCH;
    endcase
    if (rst) begin
      addr = 32'd0;
      bus  = 32'd0;
    end else begin
      addr = (state_r == MEM) ? alu_r : pc_r;
      case (state_r)
        FETCH:   bus = mem_rdata;
        DECODE:  bus = rs1_data;
        EXEC:    bus = alu_s;
        MEM:     bus = (opcode_s == OP_STORE) ? b_r : mem_rdata;
        WB:      bus = reg_wdata;
        default: bus = 32'd0;
      endcase
    end
  end

  // State, PC and datapath latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FETCH;
      pc_r    <= 32'd0;
      inst    <= 32'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      imm_r   <= 32'd0;
      alu_r   <= 32'd0;
      mdr_r   <= 32'd0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        FETCH:   inst <= mem_rdata;
        DECODE:  begin a_r <= rs1_data; b_r <= rs2_data; imm_r <= imm_s; end
        EXEC:    alu_r <= alu_s;
        MEM:     mdr_r <= load_s;
        WB:      pc_r <= npc_s;
        default: pc_r <= pc_r;
      endcase
    end
  end
endmodule

module rv #(
  parameter int MEM_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] bus,
  output logic [31:0] addr
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] mem_rdata_s, mem_wdata_s, rs1_data_s, rs2_data_s, reg_wdata_s, inst_s;
  logic [3:0]  mem_wmask_s;
  logic [4:0]  rs1_s, rs2_s, rd_s, control_lines_s;
  logic [2:0]  func3_s;
  logic        reg_we_s;

  rv_mem #(.MEM_WORDS(MEM_WORDS), .AW(AW)) m (
    .clk(clk), .word_addr(addr[AW+1:2]), .wmask(mem_wmask_s), .wdata(mem_wdata_s), .rdata(mem_rdata_s)
  );

  rv_regs r (
    .clk(clk), .rst(rst), .ra1(rs1_s), .ra2(rs2_s), .rd1(rs1_data_s), .rd2(rs2_data_s),
    .we(reg_we_s), .wa(rd_s), .wd(reg_wdata_s)
  );

  rv_ctrl c (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata_s), .mem_wmask(mem_wmask_s), .mem_wdata(mem_wdata_s),
    .rs1(rs1_s), .rs2(rs2_s), .rs1_data(rs1_data_s), .rs2_data(rs2_data_s), .reg_we(reg_we_s),
    .rd(rd_s), .reg_wdata(reg_wdata_s), .bus(bus), .addr(addr), .inst(inst_s), .func3(func3_s),
    .control_lines(control_lines_s)
  );
endmodule

// File: tb/tb_rv.sv
// Directed-vector bench for rv: programs are loaded back-door into memory and results checked
// against hand-computed register, memory and PC values.

module tb_rv;
  localparam int MEM_WORDS = 16384;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic        clk;
  logic        rst;
  logic [31:0] bus;
  logic [31:0] addr;
  int          vectors;
  int          miscompares;
  logic [31:0] held_addr;
  logic        found;

  rv #(.MEM_WORDS(MEM_WORDS)) dut (.clk(clk), .rst(rst), .bus(bus), .addr(addr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset_clear_mem();
    rst = 1'b1;
    cycles(2);
    for (int i = 0; i < MEM_WORDS; i++) dut.m.mem[i] = 32'd0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;

    // ---- Reset state and halt on ECALL ----
    hold_reset_clear_mem();
    dut.m.mem[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd3, 7'b0010011);
    dut.m.mem[1] = ECALL;
    cycles(1);
    check("reset_bus", bus, 32'd0);
    check("reset_addr", addr, 32'd0);
    check("reset_inst", dut.c.inst, 32'd0);
    rst = 1'b0;
    cycles(20);
    check("halt_inst", dut.c.inst, ECALL);
    check("halt_x3", dut.r.regs[3], 32'd1);
    check("halt_pc", addr, 32'h4);
    held_addr = addr;
    cycles(10);
    check("halt_x3_held", dut.r.regs[3], 32'd1);
    check("halt_pc_frozen", addr, held_addr);
    check("halt_inst_held", dut.c.inst, ECALL);

    // ---- Arithmetic ----
    hold_reset_clear_mem();
    dut.m.mem[0] = {20'h80000, 5'd1, 7'b0110111};
    dut.m.mem[1] = enc_i(12'hFFF, 5'd1, 3'b000, 5'd2, 7'b0010011);
    dut.m.mem[2] = enc_i(12'h404, 5'd1, 3'b101, 5'd4, 7'b0010011);
    dut.m.mem[3] = enc_r(7'd0, 5'd1, 5'd2, 3'b011, 5'd5);
    dut.m.mem[4] = enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd7);
    dut.m.mem[5] = enc_r(7'd0, 5'd2, 5'd1, 3'b010, 5'd8);
    dut.m.mem[6] = ECALL;
    rst = 1'b0;
    cycles(60);
    check("lui_x1", dut.r.regs[1], 32'h8000_0000);
    check("addi_x2", dut.r.regs[2], 32'h7FFF_FFFF);
    check("srai_x4", dut.r.regs[4], 32'hF800_0000);
    check("sltu_x5", dut.r.regs[5], 32'd1);
    check("sub_x7", dut.r.regs[7], 32'hFFFF_FFFF);
    check("slt_x8", dut.r.regs[8], 32'd1);

    // ---- Loads and stores ----
    hold_reset_clear_mem();
    dut.m.mem[0]  = {20'h12345, 5'd1, 7'b0110111};
    dut.m.mem[1]  = enc_i(12'h678, 5'd1, 3'b000, 5'd1, 7'b0010011);
    dut.m.mem[2]  = enc_i(12'h100, 5'd0, 3'b000, 5'd2, 7'b0010011);
    dut.m.mem[3]  = enc_s(12'd0, 5'd1, 5'd2, 3'b010);
    dut.m.mem[4]  = enc_i(12'd3, 5'd2, 3'b000, 5'd3, 7'b0000011);
    dut.m.mem[5]  = enc_i(12'd2, 5'd2, 3'b101, 5'd4, 7'b0000011);
    dut.m.mem[6]  = enc_i(12'hFAA, 5'd0, 3'b000, 5'd5, 7'b0010011);
    dut.m.mem[7]  = enc_s(12'd1, 5'd5, 5'd2, 3'b000);
    dut.m.mem[8]  = enc_i(12'd1, 5'd2, 3'b000, 5'd6, 7'b0000011);
    dut.m.mem[9]  = enc_i(12'd0, 5'd2, 3'b001, 5'd7, 7'b0000011);
    dut.m.mem[10] = ECALL;
    rst = 1'b0;
    cycles(100);
    check("lb_0x103", dut.r.regs[3], 32'h0000_0012);
    check("lhu_0x102", dut.r.regs[4], 32'h0000_1234);
    check("sb_word", dut.m.mem[32'h100 >> 2], 32'h1234_AA78);
    check("lb_sext", dut.r.regs[6], 32'hFFFF_FFAA);
    check("lh_sext", dut.r.regs[7], 32'hFFFF_AA78);

    // ---- Control flow ----
    hold_reset_clear_mem();
    dut.m.mem[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd2, 7'b0010011);
    dut.m.mem[1]  = enc_i(12'd5, 5'd0, 3'b000, 5'd3, 7'b0010011);
    dut.m.mem[2]  = enc_b(13'd24, 5'd3, 5'd2, 3'b000);
    dut.m.mem[3]  = enc_i(12'd99, 5'd0, 3'b000, 5'd9, 7'b0010011);
    dut.m.mem[8]  = enc_j(21'd8, 5'd1);
    dut.m.mem[9]  = ECALL;
    dut.m.mem[10] = enc_i(12'd0, 5'd1, 3'b000, 5'd0, 7'b1100111);
    dut.m.mem[11] = enc_i(12'd1, 5'd0, 3'b000, 5'd10, 7'b0010011);
    rst = 1'b0;
    cycles(60);
    check("jal_link", dut.r.regs[1], 32'h24);
    check("jalr_pc", addr, 32'h24);
    check("beq_skipped", dut.r.regs[9], 32'd0);
    check("after_jalr_skipped", dut.r.regs[10], 32'd0);
    check("flow_halted", dut.c.inst, ECALL);

    // ---- x0 hard-wired ----
    hold_reset_clear_mem();
    dut.m.mem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011);
    dut.m.mem[1] = enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd6);
    dut.m.mem[2] = ECALL;
    rst = 1'b0;
    cycles(30);
    check("x0_zero", dut.r.regs[0], 32'd0);
    check("add_x6", dut.r.regs[6], 32'd0);

    // ---- Reset during the MEM state of a store ----
    hold_reset_clear_mem();
    dut.m.mem[0]  = enc_i(12'd7, 5'd0, 3'b000, 5'd1, 7'b0010011);
    dut.m.mem[1]  = enc_i(12'h100, 5'd0, 3'b000, 5'd2, 7'b0010011);
    dut.m.mem[2]  = enc_s(12'd0, 5'd1, 5'd2, 3'b010);
    dut.m.mem[3]  = ECALL;
    dut.m.mem[64] = 32'hDEAD_BEEF;
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycles(1);
      if (addr == 32'h100) begin
        found = 1'b1;
        break;
      end
    end
    check("sw_mem_reached", {31'd0, found}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_addr", addr, 32'd0);
    check("abort_x1", dut.r.regs[1], 32'd0);
    cycles(1);
    check("abort_mem", dut.m.mem[64], 32'hDEAD_BEEF);
    rst = 1'b0;
    cycles(40);
    check("restart_mem", dut.m.mem[64], 32'd7);
    check("restart_pc", addr, 32'hC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
